turbo_deitl_buf: RTL and testbench

Frame-based turbo de-interleaver buffer: the read-side counterpart of the turbo interleaver memory. Symbols arrive in interleaved order over a valid/ready stream. Each symbol is written to the internal RAM at the natural-order address pi(k), fetched from the external interleaver ROM. Once the frame is complete, the RAM is read out sequentially in natural order on a valid/ready output stream for the decoder.

---
 rtl/turbo_deitl_buf.sv | 152 +++++++++++++++
 tb/tb_turbo_deitl_buf.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_deitl_buf.sv
// Turbo de-interleaver buffer: writes interleaved symbols to RAM at pi(k), then streams them out in natural order.
// Optional build macro TURBO_DEITL_CHK_EN flags and drops writes whose pi(k) falls outside the current frame.
module turbo_deitl_buf #(
   parameter int D_WIDTH = 13,
   parameter int A_WIDTH = 16,
   parameter int MAX_LEN = 6144
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               i_start,
   input  logic [A_WIDTH-1:0] i_frame_len,
   input  logic               i_in_valid,
   input  logic [D_WIDTH-1:0] i_in_data,
   output logic               o_in_ready,
   output logic [A_WIDTH-1:0] o_rom_addr,
   input  logic [A_WIDTH-1:0] i_rom_data,
   output logic               o_out_valid,
   output logic [D_WIDTH-1:0] o_out_data,
   output logic               o_out_last,
   input  logic               i_out_ready,
   output logic               o_busy,
   output logic               o_err
);

   localparam int RAM_AW = $clog2(MAX_LEN);
   localparam logic [A_WIDTH-1:0] MAX_LEN_A = A_WIDTH'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ} state_t;
   state_t r_state, w_state_nxt;

   logic [A_WIDTH-1:0] r_len, r_k, r_j;
   logic               r_err, r_rd_done;
   logic [D_WIDTH-1:0] r_ram [0:MAX_LEN-1];
   logic [D_WIDTH-1:0] r_rdata;
   logic               r_rd_vld, r_rd_last;
   logic [D_WIDTH-1:0] r_buf [0:1];
   logic [1:0]         r_buf_last;
   logic [1:0]         r_cnt;
   logic               r_rp;

   logic               w_len_ok, w_start_ok, w_start_bad, w_accept, w_k_last;
   logic               w_wr_en, w_chk_err;
   logic               w_out_valid, w_head_last, w_pop, w_pop_buf, w_push, w_issue, w_done;
   logic [D_WIDTH-1:0] w_head_data;
   logic [2:0]         w_occ;
   logic               w_wp;

   assign w_len_ok    = (i_frame_len != '0) && (i_frame_len <= MAX_LEN_A);
   assign w_start_ok  = (r_state == S_IDLE) && i_start && w_len_ok;
   assign w_start_bad = (r_state == S_IDLE) && i_start && !w_len_ok;
   assign w_accept    = (r_state == S_LOAD) && i_in_valid;
   assign w_k_last    = (r_k == r_len - 1'b1);

`ifdef TURBO_DEITL_CHK_EN
   assign w_wr_en   = w_accept && (i_rom_data < MAX_LEN_A) && (i_rom_data < r_len);
   assign w_chk_err = w_accept && (i_rom_data >= r_len);
`else
   assign w_wr_en   = w_accept && (i_rom_data < MAX_LEN_A);
   assign w_chk_err = 1'b0;
`endif

   // Output head comes from the 2-entry buffer when it holds data, else straight from the RAM read register.
   assign w_out_valid = (r_cnt != 2'd0) || r_rd_vld;
   assign w_head_data = (r_cnt != 2'd0) ? r_buf[r_rp]      : r_rdata;
   assign w_head_last = (r_cnt != 2'd0) ? r_buf_last[r_rp] : r_rd_last;
   assign w_pop       = w_out_valid && i_out_ready;
   assign w_pop_buf   = w_pop && (r_cnt != 2'd0);
   assign w_push      = r_rd_vld && !(w_pop && (r_cnt == 2'd0));
   assign w_wp        = r_rp ^ r_cnt[0];
   assign w_done      = w_pop && w_head_last;

   // Issue a read only if buffer plus in-flight data still fits in two slots after this cycle's pop.
   assign w_occ   = {1'b0, r_cnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};
   assign w_issue = (r_state == S_READ) && !r_rd_done && (w_occ < 3'd2);

   assign o_in_ready  = (r_state == S_LOAD);
   assign o_rom_addr  = (r_state != S_LOAD) ? '0 : (w_accept ? r_k + 1'b1 : r_k);
   assign o_out_valid = w_out_valid;
   assign o_out_data  = w_out_valid ? w_head_data : '0;
   assign o_out_last  = w_out_valid && w_head_last;
   assign o_busy      = (r_state != S_IDLE);
   assign o_err       = r_err;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_start_ok) w_state_nxt = S_LOAD;
         S_LOAD: if (w_accept && w_k_last) w_state_nxt = S_READ;
         S_READ: if (w_done) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= S_IDLE;
         r_len     <= '0;
         r_k       <= '0;
         r_j       <= '0;
         r_err     <= 1'b0;
         r_rd_done <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start_ok) begin
            r_len     <= i_frame_len;
            r_k       <= '0;
            r_j       <= '0;
            r_err     <= 1'b0;
            r_rd_done <= 1'b0;
         end else begin
            if (w_start_bad || w_chk_err) r_err <= 1'b1;
            if (w_accept) r_k <= r_k + 1'b1;
            if (w_issue) begin
               if (r_j == r_len - 1'b1) r_rd_done <= 1'b1;
               else                     r_j       <= r_j + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_rd_vld   <= 1'b0;
         r_rd_last  <= 1'b0;
         r_cnt      <= 2'd0;
         r_rp       <= 1'b0;
         r_buf_last <= 2'b00;
         r_buf[0]   <= '0;
         r_buf[1]   <= '0;
      end else if (w_start_ok) begin
         r_rd_vld <= 1'b0;
         r_cnt    <= 2'd0;
         r_rp     <= 1'b0;
      end else begin
         r_rd_vld <= w_issue;
         if (w_issue) r_rd_last <= (r_j == r_len - 1'b1);
         if (w_push) begin
            r_buf[w_wp]      <= r_rdata;
            r_buf_last[w_wp] <= r_rd_last;
         end
         if (w_pop_buf) r_rp <= ~r_rp;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop_buf};
      end
   end

   // Frame storage is intentionally not reset; unwritten natural addresses return stale data.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_ram[i_rom_data[RAM_AW-1:0]] <= i_in_data;
      if (w_issue) r_rdata <= r_ram[r_j[RAM_AW-1:0]];
   end

endmodule

// File: tb/tb_turbo_deitl_buf.sv
// Directed bench for turbo_deitl_buf: expected outputs queued at frame start, checked by an independent monitor.
module tb_turbo_deitl_buf;
   localparam int DW = 13;
   localparam int AW = 16;
   localparam int ML = 6144;
`ifdef TURBO_DEITL_CHK_EN
   localparam logic CHK_ERR = 1'b1;
`else
   localparam logic CHK_ERR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] frame_len = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic [AW-1:0] rom_addr;
   logic [AW-1:0] rom_data = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready = 1'b1;
   logic          busy;
   logic          err;

   always #5 clk = ~clk;

   turbo_deitl_buf #(.D_WIDTH(DW), .A_WIDTH(AW), .MAX_LEN(ML)) dut (
      .clk(clk), .n_rst(n_rst), .i_start(start), .i_frame_len(frame_len),
      .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
      .o_rom_addr(rom_addr), .i_rom_data(rom_data),
      .o_out_valid(out_valid), .o_out_data(out_data), .o_out_last(out_last),
      .i_out_ready(out_ready), .o_busy(busy), .o_err(err)
   );

   // Registered interleaver ROM, one-cycle latency
   logic [AW-1:0] pi_tab [0:7];
   always @(posedge clk) rom_data <= (rom_addr < 16'd8) ? pi_tab[rom_addr[2:0]] : '0;

   int checks = 0;
   int failures = 0;
   logic [DW:0] exp_q [$];
   logic bp = 1'b0;
   int   bp_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         if (bp) begin
            out_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
            bp_cnt++;
         end else out_ready = 1'b1;
      end
   end

   // Monitor: hold check during stalls and scoreboard pop on each transfer
   logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [DW-1:0] pd = '0;
   logic [DW:0]   e;
   initial begin
      forever begin
         @(negedge clk);
         if (n_rst && out_valid) begin
            if (pv && !pr) begin
               chk("hold_data", out_data, pd);
               chk("hold_last", out_last, pl);
            end
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_out actual=%0d required=none", out_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", out_data, e[DW-1:0]);
                  chk("out_last", out_last, e[DW]);
               end
            end
         end
         pv = n_rst && out_valid; pr = out_ready; pd = out_data; pl = out_last;
      end
   end

   task automatic step; @(posedge clk); #2; endtask

   task automatic set_pi(input int a, input int b, input int c, input int d);
      pi_tab[0] = AW'(a); pi_tab[1] = AW'(b); pi_tab[2] = AW'(c); pi_tab[3] = AW'(d);
   endtask

   task automatic push_exp(input int d, input logic last);
      exp_q.push_back({last, DW'(d)});
   endtask

   task automatic start_frame(input int len);
      start = 1'b1; frame_len = AW'(len);
      step;
      start = 1'b0;
   endtask

   task automatic send(input int d, input int gap, input int k);
      in_valid = 1'b0;
      repeat (gap) begin
         #1; chk("rom_addr_gap", rom_addr, k);
         step;
      end
      in_valid = 1'b1; in_data = DW'(d);
      #1;
      chk("rom_addr_acc", rom_addr, k + 1);
      chk("in_ready_load", in_ready, 1);
      step;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 200) begin step; n++; end
      chk(name, busy, 0);
      chk({name, "_q_empty"}, exp_q.size(), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_rom_addr"}, rom_addr, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8; i++) pi_tab[i] = '0;
      repeat (3) step;
      chk_reset_vals("rst");
      n_rst = 1'b1;
      step;

      // Basic permutation, with read latency probe
      set_pi(2, 0, 3, 1);
      push_exp(11, 0); push_exp(13, 0); push_exp(10, 0); push_exp(12, 1);
      start_frame(4);
      chk("start_busy", busy, 1);
      chk("start_in_ready", in_ready, 1);
      send(10, 0, 0); send(11, 0, 1); send(12, 0, 2); send(13, 0, 3);
      #1;
      chk("read_entry_in_ready", in_ready, 0);
      chk("read_entry_valid", out_valid, 0);
      step; #1;
      chk("first_valid", out_valid, 1);
      chk("first_data", out_data, 11);
      wait_idle("basic_done");

      // Backpressure plus input gaps
      bp = 1'b1; bp_cnt = 0;
      push_exp(21, 0); push_exp(23, 0); push_exp(20, 0); push_exp(22, 1);
      start_frame(4);
      send(20, 1, 0); send(21, 0, 1); send(22, 2, 2); send(23, 1, 3);
      wait_idle("bp_done");
      bp = 1'b0;

      // Illegal lengths
      start_frame(0); #1;
      chk("len0_err", err, 1); chk("len0_busy", busy, 0); chk("len0_in_ready", in_ready, 0);
      step;
      start_frame(ML + 1); #1;
      chk("lenmax_err", err, 1); chk("lenmax_busy", busy, 0); chk("lenmax_in_ready", in_ready, 0);
      step;

      // Out-of-range permutation entry; natural index 3 keeps 22 from the previous frame
      set_pi(0, 5, 1, 2);
      push_exp(30, 0); push_exp(32, 0); push_exp(33, 0); push_exp(22, 1);
      start_frame(4); #1;
      chk("err_cleared", err, 0);
      send(30, 0, 0);
      chk("oor_err_1st", err, 0);
      send(31, 0, 1);
      chk("oor_err_2nd", err, CHK_ERR);
      send(32, 0, 2); send(33, 0, 3);
      wait_idle("oor_done");
      chk("oor_err_end", err, CHK_ERR);

      // Reset in the middle of LOAD
      set_pi(2, 0, 3, 1);
      start_frame(4);
      send(40, 0, 0); send(41, 0, 1);
      n_rst = 1'b0; #1;
      chk_reset_vals("midrst");
      step; step;
      n_rst = 1'b1;
      step;
      set_pi(1, 0, 0, 0);
      push_exp(8, 0); push_exp(7, 1);
      start_frame(2);
      send(7, 0, 0); send(8, 0, 1);
      wait_idle("postrst_done");

      // Back-to-back frames; a start during READ must be ignored
      set_pi(1, 0, 0, 0);
      push_exp(51, 0); push_exp(50, 1);
      start_frame(2);
      send(50, 0, 0); send(51, 0, 1);
      set_pi(2, 0, 1, 0);
      start = 1'b1; frame_len = 16'd3;
      step;
      start = 1'b0; #1;
      chk("ign_start_busy", busy, 1);
      n = 0;
      while (!(out_valid && out_ready && out_last) && n < 50) begin step; #1; n++; end
      chk("b2b_last_seen", out_last, 1);
      step;
      chk("b2b_idle", busy, 0);
      push_exp(61, 0); push_exp(62, 0); push_exp(60, 1);
      start_frame(3);
      chk("b2b_start_busy", busy, 1);
      send(60, 0, 0); send(61, 0, 1); send(62, 0, 2);
      wait_idle("b2b_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
